// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential 16x16 unsigned shift-and-add multiplier.
// It takes one iteration per significant multiplier bit. The result and its
// overflow flag are held until the next operation completes.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; clears all state
//   start  - begin a multiply; sampled only while idle
//   a_bi   - 16-bit unsigned multiplicand, latched when start is accepted
//   b_bi   - 16-bit unsigned multiplier, latched when start is accepted
//   busy_o - high while an operation is in progress
//   done_o - one-cycle pulse in the cycle the result becomes valid
//   y_bo   - low 16 bits of the last completed product
//   ovf_o  - last completed product did not fit in 16 bits
module shift_add_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a_bi,
  input  logic [15:0] b_bi,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] y_bo,
  output logic        ovf_o
);

  localparam int unsigned OP_W  = 16;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] MAX_ITER = CNT_W'(OP_W);

  typedef enum logic {IDLE, WORK} state_t;

  state_t             state, state_d;
  logic [ACC_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_sum;
  logic               busy_d, done_d, ovf_d;
  logic [OP_W-1:0]    y_d;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    y_d     = y_bo;
    ovf_d   = ovf_o;
    acc_sum = acc_q + (b_q[0] ? a_q : '0);

    case (state)
      IDLE: begin
        if (start) begin
          a_d     = {{(ACC_W-OP_W){1'b0}}, a_bi};
          b_d     = b_bi;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = WORK;
          busy_d  = 1'b1;
        end
      end
      WORK: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Finish once no multiplier bits remain; the counter bounds the loop.
        if (b_d == '0 || cnt_d == MAX_ITER) begin
          state_d = IDLE;
          done_d  = 1'b1;
          y_d     = acc_sum[OP_W-1:0];
          ovf_d   = |acc_sum[ACC_W-1:OP_W];
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      y_bo   <= '0;
      ovf_o  <= 1'b0;
    end else begin
      state  <= state_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_o <= busy_d;
      done_o <= done_d;
      y_bo   <= y_d;
      ovf_o  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed and random checks of shift_add_mult against an
// arithmetic reference model (plain a*b, with cycle count taken from the
// highest set bit of b).
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_bi, b_bi;
  logic        busy_o, done_o, ovf_o;
  logic [15:0] y_bo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_y = '0;
  logic        exp_ovf = 1'b0;

  shift_add_mult dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_bi   (a_bi),
    .b_bi   (b_bi),
    .busy_o (busy_o),
    .done_o (done_o),
    .y_bo   (y_bo),
    .ovf_o  (ovf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Expected WORK length: position of highest set bit of b, plus one; b=0 -> 1
  function automatic int exp_cycles(logic [15:0] b);
    int n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Called at a negedge with the DUT able to accept start. Returns at the
  // negedge of the done cycle with start low.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit noise);
    int          n;
    int          cycles;
    logic [31:0] p;
    n = exp_cycles(b);
    p = 32'(a) * 32'(b);
    start = 1'b1; a_bi = a; b_bi = b;
    @(negedge clk);
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 40) begin
      cycles++;
      check("done_low_in_work", 32'(done_o), 32'(0));
      check("y_hold_in_work", 32'(y_bo), 32'(exp_y));
      check("ovf_hold_in_work", 32'(ovf_o), 32'(exp_ovf));
      if (noise) begin
        start = 1'b1; a_bi = 16'd9; b_bi = 16'd9;
      end else begin
        start = 1'b0; a_bi = 16'($urandom); b_bi = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_y   = p[15:0];
    exp_ovf = |p[31:16];
    check("busy_cycles", 32'(cycles), 32'(n));
    check("done_pulse", 32'(done_o), 32'(1));
    check("busy_low_at_done", 32'(busy_o), 32'(0));
    check("y_result", 32'(y_bo), 32'(exp_y));
    check("ovf_result", 32'(ovf_o), 32'(exp_ovf));
  endtask

  initial begin
    int          last_done;
    int          n_done;
    logic [15:0] ra, rb;

    // Reset overrides a pending start
    rst = 1'b1; start = 1'b1; a_bi = 16'd5; b_bi = 16'd5;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_done", 32'(done_o), 32'(0));
    check("rst_y", 32'(y_bo), 32'(0));
    check("rst_ovf", 32'(ovf_o), 32'(0));

    // First start on the first edge after reset release
    rst = 1'b0;
    do_op(16'd3, 16'd5, 1'b0);
    do_op(16'h00FF, 16'h0101, 1'b0);
    do_op(16'h0100, 16'h0100, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    do_op(16'd7, 16'd0, 1'b0);
    do_op(16'd0, 16'h00F0, 1'b0);
    @(negedge clk);
    check("done_single_pulse", 32'(done_o), 32'(0));
    check("idle_y_hold", 32'(y_bo), 32'(exp_y));

    // Start re-asserted during WORK is ignored
    do_op(16'd2, 16'h0080, 1'b1);
    @(negedge clk);
    check("no_restart_after_noise", 32'(busy_o), 32'(0));

    // Reset on the 4th WORK cycle aborts the operation
    start = 1'b1; a_bi = 16'h1234; b_bi = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (3) begin
      if (done_o === 1'b1) n_done++;
      @(negedge clk);
    end
    check("busy_before_abort", 32'(busy_o), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (done_o === 1'b1) n_done++;
    check("abort_no_done", 32'(n_done), 32'(0));
    check("abort_busy", 32'(busy_o), 32'(0));
    check("abort_y", 32'(y_bo), 32'(0));
    check("abort_ovf", 32'(ovf_o), 32'(0));
    exp_y = '0; exp_ovf = 1'b0;
    do_op(16'd6, 16'd7, 1'b0);

    // Start held high: one result every N+1 = 3 cycles
    start = 1'b1; a_bi = 16'd2; b_bi = 16'd3;
    last_done = 0; n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        n_done++;
        check("stream_y", 32'(y_bo), 32'(6));
        check("stream_period", 32'(c - last_done), 32'(3));
        last_done = c;
      end
    end
    start = 1'b0;
    check("stream_count", 32'(n_done), 32'(4));
    exp_y = 16'd6; exp_ovf = 1'b0;

    // Random operands with random idle gaps
    for (int k = 0; k < 24; k++) begin
      ra = (k % 6 == 5) ? 16'd0 : 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap_done_low", 32'(done_o), 32'(0));
        check("gap_busy_low", 32'(busy_o), 32'(0));
        check("gap_y_hold", 32'(y_bo), 32'(exp_y));
      end
      do_op(ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
